// File: rtl/coax_pkg.sv
`default_nettype none
// ============================================================================
// Package  : coax_pkg
// Desc     : Protocol constants for the 3270 coax interface, shared by the
//            transmit and receive paths, plus a word parity helper.
// Revision : 1.0 - initial release
// ============================================================================
package coax_pkg;

    localparam int COAX_QUIESCE_BITS  = 5;
    localparam int COAX_WORD_BITS     = 10;
    localparam int COAX_CV_HALF_CELLS = 3;

    typedef logic [COAX_WORD_BITS-1:0] coax_word_t;

    // Parity cell value: XOR of all data bits, so data plus parity is even.
    function automatic logic coax_parity(input coax_word_t word);
        return ^word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/coax_tx_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : coax_tx_bit_timer
// Desc     : Counts clocks inside a bit cell. half_tick strobes on the last
//            clock of each half cell, bit_tick on the last clock of the cell.
//            restart holds the count at zero so a frame starts cell-aligned.
// Revision : 1.0 - initial release
// ============================================================================
module coax_tx_bit_timer #(
    parameter int CLOCKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic half_tick,
    output logic bit_tick,
    output logic second_half
);

    localparam int c_count_w = $clog2(CLOCKS_PER_BIT);
    localparam logic [c_count_w-1:0] c_last_count = c_count_w'(CLOCKS_PER_BIT - 1);
    localparam logic [c_count_w-1:0] c_half_last  = c_count_w'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [c_count_w-1:0] c_half_first = c_count_w'(CLOCKS_PER_BIT / 2);

    logic [c_count_w-1:0] r_count;

    // Free-running cell counter, wraps at the end of each cell.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (restart || (r_count == c_last_count)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign bit_tick    = (r_count == c_last_count);
    assign half_tick   = (r_count == c_half_last) || bit_tick;
    assign second_half = (r_count >= c_half_first);

endmodule
`default_nettype wire

// File: rtl/coax_tx.sv
`default_nettype none
// ============================================================================
// Module   : coax_tx
// Desc     : 3270 coax transmitter. Accepts 10-bit words on valid/ready and
//            sends a Manchester frame: quiesce, code violation, then one
//            sync/data/parity group per word, then the end sequence.
//            A one-word holding register lets back-to-back words chain.
// Config   : COAX_TX_PREEMPHASIS_EN - builds the tx_delay pre-emphasis tap
//            (tx delayed by CLOCKS_PER_BIT/4); otherwise tx_delay is 0.
// Revision : 1.0 - initial release
// ============================================================================
module coax_tx
    import coax_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [COAX_WORD_BITS-1:0] data,
    input  logic                      valid,
    output logic                      ready,
    output logic                      tx,
    output logic                      tx_delay,
    output logic                      active
);

    if ((CLOCKS_PER_BIT < 4) || (CLOCKS_PER_BIT % 4 != 0)) begin : g_bad_clocks_per_bit
        $error("coax_tx: CLOCKS_PER_BIT must be a non-zero multiple of 4");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_QUIESCE = 3'd1,
        S_CV      = 3'd2,
        S_SYNC    = 3'd3,
        S_DATA    = 3'd4,
        S_PARITY  = 3'd5,
        S_END     = 3'd6
    } state_t;

    // r_cell counts whole cells in QUIESCE/DATA and half cells in CV/END.
    localparam int c_cell_w = $clog2(COAX_WORD_BITS);
    localparam logic [c_cell_w-1:0] c_quiesce_last = c_cell_w'(COAX_QUIESCE_BITS - 1);
    localparam logic [c_cell_w-1:0] c_cv_high      = c_cell_w'(COAX_CV_HALF_CELLS);
    localparam logic [c_cell_w-1:0] c_cv_last      = c_cell_w'(2 * COAX_CV_HALF_CELLS - 1);
    localparam logic [c_cell_w-1:0] c_word_last    = c_cell_w'(COAX_WORD_BITS - 1);
    localparam logic [c_cell_w-1:0] c_end_last     = c_cell_w'(2);

    state_t                   r_state;
    state_t                   w_next_state;
    coax_word_t               r_hold;
    logic                     r_hold_full;
    coax_word_t               r_shift;
    logic                     r_parity;
    logic [c_cell_w-1:0]      r_cell;

    logic                     w_accept;
    logic                     w_word_avail;
    coax_word_t               w_load_word;
    logic                     w_load;
    logic                     w_cell_clr;
    logic                     w_cell_inc;
    logic                     w_tx;
    logic                     w_active;
    logic                     w_restart;
    logic                     w_half_tick;
    logic                     w_bit_tick;
    logic                     w_second_half;

    assign w_accept     = valid && !r_hold_full;
    // A word arriving on the deciding edge counts as available, so a word
    // accepted in the last PARITY clock still chains without a gap.
    assign w_word_avail = r_hold_full || w_accept;
    assign w_load_word  = r_hold_full ? r_hold : data;
    assign w_active     = (r_state != S_IDLE);
    assign w_restart    = (r_state == S_IDLE);

    coax_tx_bit_timer #(
        .CLOCKS_PER_BIT (CLOCKS_PER_BIT)
    ) u_bit_timer (
        .clk         (clk),
        .reset       (reset),
        .restart     (w_restart),
        .half_tick   (w_half_tick),
        .bit_tick    (w_bit_tick),
        .second_half (w_second_half)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, line level and datapath controls.
    always_comb begin
        w_next_state = r_state;
        w_tx         = 1'b0;
        w_load       = 1'b0;
        w_cell_clr   = 1'b0;
        w_cell_inc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cell_clr = 1'b1;
                if (w_word_avail) begin
                    w_next_state = S_QUIESCE;
                end
            end
            S_QUIESCE: begin
                w_tx = ~w_second_half;
                if (w_bit_tick) begin
                    if (r_cell == c_quiesce_last) begin
                        w_next_state = S_CV;
                        w_cell_clr   = 1'b1;
                    end else begin
                        w_cell_inc = 1'b1;
                    end
                end
            end
            S_CV: begin
                w_tx = (r_cell < c_cv_high);
                if (w_half_tick) begin
                    if (r_cell == c_cv_last) begin
                        w_next_state = S_SYNC;
                        w_load       = 1'b1;
                        w_cell_clr   = 1'b1;
                    end else begin
                        w_cell_inc = 1'b1;
                    end
                end
            end
            S_SYNC: begin
                w_tx = ~w_second_half;
                if (w_bit_tick) begin
                    w_next_state = S_DATA;
                end
            end
            S_DATA: begin
                w_tx = r_shift[COAX_WORD_BITS-1] ^ w_second_half;
                if (w_bit_tick) begin
                    if (r_cell == c_word_last) begin
                        w_next_state = S_PARITY;
                        w_cell_clr   = 1'b1;
                    end else begin
                        w_cell_inc = 1'b1;
                    end
                end
            end
            S_PARITY: begin
                w_tx = r_parity ^ w_second_half;
                if (w_bit_tick) begin
                    if (w_word_avail) begin
                        w_next_state = S_SYNC;
                        w_load       = 1'b1;
                    end else begin
                        w_next_state = S_END;
                    end
                end
            end
            S_END: begin
                // Low half, high half, then one extra high half cell.
                w_tx = (r_cell != '0);
                if (w_half_tick) begin
                    if (r_cell == c_end_last) begin
                        w_next_state = S_IDLE;
                        w_cell_clr   = 1'b1;
                    end else begin
                        w_cell_inc = 1'b1;
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Cell counter, holding register and output shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cell      <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_shift     <= '0;
            r_parity    <= 1'b0;
        end else begin
            if (w_cell_clr) begin
                r_cell <= '0;
            end else if (w_cell_inc) begin
                r_cell <= r_cell + 1'b1;
            end

            if (w_load) begin
                r_shift  <= w_load_word;
                r_parity <= coax_parity(w_load_word);
            end else if ((r_state == S_DATA) && w_bit_tick) begin
                r_shift <= r_shift << 1;
            end

            // A load with the register empty takes the input word directly,
            // so the holding register only fills on a non-loading accept.
            if (w_accept && !w_load) begin
                r_hold      <= data;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    assign ready  = ~r_hold_full;
    assign tx     = w_tx;
    assign active = w_active;

`ifdef COAX_TX_PREEMPHASIS_EN
    localparam int c_delay = CLOCKS_PER_BIT / 4;

    logic w_delay_tap;

    if (c_delay == 1) begin : g_delay_one
        logic r_delay;
        // Single-stage delay line, emptied whenever no frame is on the line.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_delay <= 1'b0;
            end else if (!w_active) begin
                r_delay <= 1'b0;
            end else begin
                r_delay <= w_tx;
            end
        end
        assign w_delay_tap = r_delay;
    end else begin : g_delay_multi
        logic [c_delay-1:0] r_delay;
        // Delay line for tx, emptied whenever no frame is on the line.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_delay <= '0;
            end else if (!w_active) begin
                r_delay <= '0;
            end else begin
                r_delay <= {r_delay[c_delay-2:0], w_tx};
            end
        end
        assign w_delay_tap = r_delay[c_delay-1];
    end

    assign tx_delay = w_delay_tap & w_active;
`else
    assign tx_delay = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_coax_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_coax_tx
// Desc     : Self-checking bench for coax_tx. Expected line waveforms are
//            built cell by cell from the frame format; ready is predicted
//            from the word accept/sync schedule of each scenario.
// Config   : COAX_TX_PREEMPHASIS_EN - expect tx_delay as tx lagged by
//            CLOCKS_PER_BIT/4 within a frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_coax_tx;
    import coax_pkg::*;

    localparam int CPB        = 16;
    localparam int HALF       = CPB / 2;
    localparam int START_CLKS = (2 * COAX_QUIESCE_BITS + 2 * COAX_CV_HALF_CELLS) * HALF;
    localparam int WORD_CLKS  = (COAX_WORD_BITS + 2) * CPB;
    localparam int END_CLKS   = 3 * HALF;
    localparam int FRAME1     = START_CLKS + WORD_CLKS + END_CLKS;
`ifdef COAX_TX_PREEMPHASIS_EN
    localparam int DLY        = CPB / 4;
`endif

    logic                      clk = 1'b0;
    logic                      reset;
    logic [COAX_WORD_BITS-1:0] data;
    logic                      valid;
    logic                      ready;
    logic                      tx;
    logic                      tx_delay;
    logic                      active;

    coax_tx #(
        .CLOCKS_PER_BIT (CPB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .tx       (tx),
        .tx_delay (tx_delay),
        .active   (active)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected per-clock waveforms, index 0 = clock after the first accept.
    bit exp_tx[$];
    bit exp_act[$];
    bit exp_dly[$];
    bit frame_q[$];
    // Word schedule: valid high on [vs, va-1], accepted into cycle va,
    // its sync cell starts at cycle s.
    logic [COAX_WORD_BITS-1:0] sched_w[$];
    int sched_vs[$];
    int sched_va[$];
    int sched_s[$];
    logic [COAX_WORD_BITS-1:0] words[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        exp_tx.delete();
        exp_act.delete();
        exp_dly.delete();
        sched_w.delete();
        sched_vs.delete();
        sched_va.delete();
        sched_s.delete();
    endtask

    task automatic push_level(input bit lvl, input int clocks);
        repeat (clocks) frame_q.push_back(lvl);
    endtask

    task automatic push_cell(input bit b);
        push_level(b, HALF);
        push_level(!b, HALF);
    endtask

    task automatic add_idle(input int clocks);
        repeat (clocks) begin
            exp_tx.push_back(1'b0);
            exp_act.push_back(1'b0);
            exp_dly.push_back(1'b0);
        end
    endtask

    // One frame carrying every entry of `words`.
    task automatic add_frame();
        logic [COAX_WORD_BITS-1:0] w;
        frame_q.delete();
        for (int i = 0; i < COAX_QUIESCE_BITS; i++) push_cell(1'b1);
        push_level(1'b1, COAX_CV_HALF_CELLS * HALF);
        push_level(1'b0, COAX_CV_HALF_CELLS * HALF);
        foreach (words[j]) begin
            w = words[j];
            push_cell(1'b1);
            for (int b = COAX_WORD_BITS - 1; b >= 0; b--) push_cell(w[b]);
            push_cell(^w);
        end
        push_cell(1'b0);
        push_level(1'b1, HALF);
        foreach (frame_q[i]) begin
            exp_tx.push_back(frame_q[i]);
            exp_act.push_back(1'b1);
`ifdef COAX_TX_PREEMPHASIS_EN
            exp_dly.push_back((i >= DLY) ? frame_q[i-DLY] : 1'b0);
`else
            exp_dly.push_back(1'b0);
`endif
        end
    endtask

    task automatic add_sched(input logic [COAX_WORD_BITS-1:0] w, input int vs, input int va, input int s);
        sched_w.push_back(w);
        sched_vs.push_back(vs);
        sched_va.push_back(va);
        sched_s.push_back(s);
    endtask

    // Schedule for `words` sent with valid held high, frame entered at base.
    task automatic sched_chain(input int base);
        int va;
        int s;
        for (int j = 0; j < words.size(); j++) begin
            if (j == 0) begin
                add_sched(words[j], base - 1, base, base + START_CLKS);
                va = base;
                s  = base + START_CLKS;
            end else begin
                add_sched(words[j], va, s + 1, s + WORD_CLKS);
                va = s + 1;
                s  = s + WORD_CLKS;
            end
        end
    endtask

    // Drives the schedule and compares every clock up to stop_at.
    task automatic run_model(input string name, input int stop_at, input int act_len);
        int  act_cnt;
        bit  rdy_e;
        act_cnt = 0;
        for (int c = -1; c < stop_at - 1; c++) begin
            valid = 1'b0;
            data  = COAX_WORD_BITS'($urandom);
            for (int j = 0; j < sched_w.size(); j++) begin
                if (c >= sched_vs[j] && c < sched_va[j]) begin
                    valid = 1'b1;
                    data  = sched_w[j];
                end
            end
            @(posedge clk);
            #1;
            rdy_e = 1'b1;
            for (int j = 0; j < sched_w.size(); j++) begin
                if (c + 1 >= sched_va[j] && c + 1 < sched_s[j]) rdy_e = 1'b0;
            end
            check($sformatf("%s tx@%0d", name, c + 1), 32'(tx), 32'(exp_tx[c+1]));
            check($sformatf("%s active@%0d", name, c + 1), 32'(active), 32'(exp_act[c+1]));
            check($sformatf("%s ready@%0d", name, c + 1), 32'(ready), 32'(rdy_e));
            check($sformatf("%s tx_delay@%0d", name, c + 1), 32'(tx_delay), 32'(exp_dly[c+1]));
            act_cnt += int'(active);
        end
        valid = 1'b0;
        if (act_len >= 0) check($sformatf("%s active length", name), act_cnt, act_len);
    endtask

    task automatic chain_test(input string name);
        clear_model();
        sched_chain(0);
        add_frame();
        add_idle(4);
        run_model(name, exp_tx.size(), START_CLKS + words.size() * WORD_CLKS + END_CLKS);
    endtask

    task automatic check_reset_values(input string name);
        check({name, " tx"}, 32'(tx), 32'(0));
        check({name, " active"}, 32'(active), 32'(0));
        check({name, " ready"}, 32'(ready), 32'(1));
        check({name, " tx_delay"}, 32'(tx_delay), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int o;
        int stop;
        reset = 1'b1;
        valid = 1'b0;
        data  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("in reset");
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        check_reset_values("idle after reset");

        // Single all-ones word: 344 active clocks
        words = '{10'h3FF};
        chain_test("single 3FF");

        // Odd-parity words
        words = '{10'h001};
        chain_test("single 001");
        words = '{10'h2AA};
        chain_test("single 2AA");

        // Three chained words, valid held high: 728 active clocks
        words = '{COAX_WORD_BITS'($urandom), COAX_WORD_BITS'($urandom), COAX_WORD_BITS'($urandom)};
        chain_test("chain3");

        // Second word offered only in the last PARITY clock, then at a random point
        for (int t = 0; t < 2; t++) begin
            o = (t == 0) ? START_CLKS + WORD_CLKS - 1
                         : int'($urandom_range(START_CLKS, START_CLKS + WORD_CLKS - 2));
            words = '{COAX_WORD_BITS'($urandom), COAX_WORD_BITS'($urandom)};
            clear_model();
            add_sched(words[0], -1, 0, START_CLKS);
            add_sched(words[1], o, o + 1, START_CLKS + WORD_CLKS);
            add_frame();
            add_idle(4);
            run_model($sformatf("offer@%0d", o), exp_tx.size(), START_CLKS + 2 * WORD_CLKS + END_CLKS);
        end

        // Word offered one clock after END begins: two separate frames
        clear_model();
        words = '{COAX_WORD_BITS'($urandom)};
        add_sched(words[0], -1, 0, START_CLKS);
        add_frame();
        add_idle(1);
        words = '{COAX_WORD_BITS'($urandom)};
        add_sched(words[0], START_CLKS + WORD_CLKS + 1, START_CLKS + WORD_CLKS + 2,
                  FRAME1 + 1 + START_CLKS);
        add_frame();
        add_idle(4);
        run_model("late word", exp_tx.size(), 2 * FRAME1);

        // Random chains
        for (int t = 0; t < 3; t++) begin
            words.delete();
            repeat ($urandom_range(1, 3)) words.push_back(COAX_WORD_BITS'($urandom));
            chain_test($sformatf("random chain %0d", t));
        end

        // Reset during DATA: outputs return to reset values without a clock edge
        words = '{COAX_WORD_BITS'($urandom)};
        clear_model();
        sched_chain(0);
        add_frame();
        stop = START_CLKS + CPB + int'($urandom_range(0, COAX_WORD_BITS * CPB - 1));
        run_model("pre-reset", stop, -1);
        #2 reset = 1'b1;
        #1;
        check_reset_values("async reset mid-frame");
        @(posedge clk);
        #1;
        check_reset_values("held reset");
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        check_reset_values("idle after mid-frame reset");

        // Clean frame after the abandoned one
        words = '{COAX_WORD_BITS'($urandom)};
        chain_test("recovery");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
